noc_rx_interface: RTL
=====================

Name: noc_rx_interface

Overview:
- Clocked network-interface receiver that terminates one tree-NoC router output port (child_out/parent_out side) at a processing element.
- Accepts 14-bit packets over the four-phase bundled-data handshake: req_in, ack_out, data_in.
- Checks the destination field against the node address, buffers accepted packets in a small FIFO, and presents them to the PE on a valid/ready interface.
- This is the receive end for what the router's output channels transmit.

Parameters:
- WIDTH_packet, 14, total packet width; fields are src[13:11], dest[10:8], payload[7:0].
- WIDTH_addr, 3, width of the src and dest fields.
- NODE_ADDR, 3'b000, address of this leaf node.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- SYNC_STAGES, 2, flops in the req_in synchronizer; at least 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_in, input, 1: four-phase request from the router, asynchronous to clk.
- data_in, input, WIDTH_packet: bundled data; stable from req_in rising until ack_out falls.
- ack_out, output, 1: four-phase acknowledge to the router.
- pkt_valid, output, 1: FIFO head is valid.
- pkt_ready, input, 1: PE accepts the head.
- pkt_src, output, WIDTH_addr: source field of the head packet.
- pkt_data, output, 8: payload of the head packet.
- drop_cnt, output, 8: count of misrouted packets; saturates at 255.
- fifo_full, output, 1: FIFO full flag.

Behaviour:
- Reset: while rst_n=0, ack_out=0, pkt_valid=0, pkt_src=0, pkt_data=0, drop_cnt=0, fifo_full=0. FIFO pointers and the synchronizer clear; the FSM goes to IDLE. Release takes effect on the first clk edge after rst_n rises.
- Synchronizer: req_in passes through SYNC_STAGES flops to give req_s. data_in is sampled only while req_s=1, so the bundled-data guarantee holds.
- FSM states: IDLE, CAPTURE, ACK_HI, WAIT_LO.
  - IDLE -> CAPTURE when req_s=1 and fifo_full=0. If req_s=1 and the FIFO is full, stay in IDLE with ack_out=0; this backpressures the router and loses nothing.
  - CAPTURE, one cycle:
    - If data_in[10:8]==NODE_ADDR, write data_in into the FIFO.
    - Otherwise discard it and increment drop_cnt, saturating at 255.
    - Then go to ACK_HI.
  - ACK_HI: ack_out=1 (registered). Go to WAIT_LO.
  - WAIT_LO: hold ack_out=1 until req_s=0, then drop ack_out to 0 and go to IDLE.
- ack_out is a registered output, glitch-free.
- Latency, req_in rising to ack_out rising: SYNC_STAGES+2 cycles.
- Minimum four-phase cycle with req_in low/high each one cycle: 2*SYNC_STAGES+4 clocks.
- FIFO: write pointer advances in CAPTURE on a match; read pointer advances on pkt_valid & pkt_ready. Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
  - pkt_valid = !empty.
  - pkt_src and pkt_data are driven combinationally from the head entry; they read 0 when empty.
- Simultaneous write and read:
  - When the FIFO is full, a read and a write in the same cycle cannot both occur, because CAPTURE is never entered while full.
  - When the FIFO is not full, a write and a read in the same cycle are both performed and the occupancy is unchanged.
- pkt_ready asserted while pkt_valid=0 is ignored.
- Reset mid-handshake: ack_out drops immediately (asynchronous). An in-flight packet not yet written is lost. After reset, if req_in is still high, it is treated as a new request.
- A packet that is dropped is still fully handshaken, so the router never stalls on a misroute.

Optional Feature:
- Macro RX_PKT_CNT_EN.
- Defined: adds output rx_cnt[15:0]. It resets to 0 and increments, wrapping, on every FIFO write (matched packets only).
- Undefined: the rx_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single matched packet: NODE_ADDR=3'b001; send data_in=14'b010_001_10101010.
  - ack_out rises 4 clk after req_in.
  - pkt_valid=1, pkt_src=3'b010, pkt_data=8'hAA.
  - With pkt_ready=1 for one cycle, pkt_valid goes to 0.
- Misroute: send dest=3'b011 with NODE_ADDR=3'b001.
  - Handshake completes; pkt_valid stays 0; drop_cnt=1.
  - 256 misroutes in total leave drop_cnt=255.
- Backpressure: DEPTH=4, pkt_ready=0, send 5 matched packets.
  - After 4 packets, fifo_full=1 and the 5th request sees ack_out held 0.
  - One pop raises ack_out within SYNC_STAGES+3 cycles; 4 entries are read out in order, then the 5th.
- Concurrent push/pop: pkt_ready held 1 while 8 back-to-back packets arrive.
  - All 8 are delivered in order; fifo_full is never asserted.
- Reset mid-operation: rst_n=0 while in WAIT_LO with 2 entries in the FIFO.
  - ack_out=0, pkt_valid=0, drop_cnt=0 in the same time step.
  - After release with req_in still high, one new capture occurs.
- RX_PKT_CNT_EN defined: 3 matched and 2 misrouted packets give rx_cnt=3 and drop_cnt=2.

Source files
------------

// File: rtl/noc_rx_interface.sv
// noc_rx_interface: receive end of a tree-NoC router output port.
// Terminates a four-phase bundled-data channel, filters packets on the
// destination field, queues matches in a small FIFO and presents them to the
// PE over valid/ready.
// Optional build macro RX_PKT_CNT_EN adds a 16-bit wrapping count of
// accepted packets (rx_cnt).
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a synchronized request while the FIFO has room
// CAPTURE | sample data_in: queue it on an address match, else count a drop
// ACK_HI  | acknowledge raised
// WAIT_LO | hold acknowledge until the request returns low
module noc_rx_interface #(
  parameter int                    WIDTH_packet = 14,
  parameter int                    WIDTH_addr   = 3,
  parameter logic [WIDTH_addr-1:0] NODE_ADDR    = 3'b000,
  parameter int                    DEPTH        = 4,
  parameter int                    SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_in,
  input  logic [WIDTH_packet-1:0] data_in,
  output logic                    ack_out,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [WIDTH_addr-1:0]   pkt_src,
  output logic [7:0]              pkt_data,
  output logic [7:0]              drop_cnt,
`ifdef RX_PKT_CNT_EN
  output logic [15:0]             rx_cnt,
`endif
  output logic                    fifo_full
);

  localparam int PAY_W = 8;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK_HI  = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic                     ack_nxt;
  logic [SYNC_STAGES-1:0]   req_sync;
  logic                     req_s;
  logic [AW:0]              wr_ptr, rd_ptr;
  logic [WIDTH_packet-1:0]  mem [DEPTH];
  logic [WIDTH_packet-1:0]  head;
  logic                     fifo_empty;
  logic                     dest_match;
  logic                     wr_en, rd_en;

  assign req_s      = req_sync[SYNC_STAGES-1];
  assign dest_match = (data_in[PAY_W +: WIDTH_addr] == NODE_ADDR);
  assign wr_en      = (state == CAPTURE) && dest_match;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pkt_valid  = !fifo_empty;
  assign rd_en      = pkt_valid && pkt_ready;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign pkt_src    = fifo_empty ? '0 : head[PAY_W+WIDTH_addr +: WIDTH_addr];
  assign pkt_data   = fifo_empty ? '0 : head[PAY_W-1:0];

  // Request synchronizer; data_in is only looked at once req_s is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_sync <= '0;
    else        req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
  end

  // Handshake state and registered acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ack_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      ack_out <= ack_nxt;
    end
  end

  // Next state; ack_nxt is the value ack_out takes in the next state, so the
  // acknowledge comes straight from a flop.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    case (state)
      IDLE:    if (req_s && !fifo_full) state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt = ACK_HI;
        ack_nxt   = 1'b1;
      end
      ACK_HI:  begin
        state_nxt = WAIT_LO;
        ack_nxt   = 1'b1;
      end
      WAIT_LO: begin
        if (!req_s) state_nxt = IDLE;
        else        ack_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // FIFO pointers, extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Misroute counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if ((state == CAPTURE) && !dest_match && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

`ifdef RX_PKT_CNT_EN
  // Accepted-packet counter, wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rx_cnt <= '0;
    else if (wr_en) rx_cnt <= rx_cnt + 16'd1;
  end
`endif

endmodule
